// File: rtl/arbiter_pkg.sv
// Shared defaults and state encoding for the round-robin arbiter slice.
package arbiter_pkg;

  localparam int unsigned N_REQ_DEF    = 8;
  localparam int unsigned IDX_W_DEF    = $clog2(N_REQ_DEF);
  localparam int unsigned MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_core_if.sv
// Request/grant bundle between requesters and the arbiter core.
interface rr_arbiter_core_if #(
  parameter int unsigned N_REQ = arbiter_pkg::N_REQ_DEF
) ();

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic             arb_en_i;
  logic [N_REQ-1:0] req_i;
  logic             grant_en_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic             busy_o;

  // Requester side: drives requests, observes the grant.
  modport master (
    output arb_en_i,
    output req_i,
    input  grant_en_o,
    input  grant_idx_o,
    input  busy_o
  );

  // Arbiter side: samples requests, drives the grant.
  modport slave (
    input  arb_en_i,
    input  req_i,
    output grant_en_o,
    output grant_idx_o,
    output busy_o
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set bit of req at or after start, wrapping.
module rr_priority_pick #(
  parameter int unsigned N_REQ = 8
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] start,
  output logic                     found_c,
  output logic [$clog2(N_REQ)-1:0] idx_c
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  // Rotate so start sits at bit 0, find the lowest set bit, add start back (wraps mod N_REQ).
  always_comb begin
    rot     = N_REQ'({req, req} >> start);
    found_c = 1'b0;
    off     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found_c && rot[i]) begin
        found_c = 1'b1;
        off     = IDX_W'(i);
      end
    end
    idx_c = start + off;
  end

endmodule

// File: rtl/rr_arbiter_core.sv
// Round-robin arbiter with grant hold and preemption after MAX_HOLD contended cycles.
module rr_arbiter_core
  import arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_arbiter_core_if.slave   arb
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned HC_W  = $clog2(MAX_HOLD) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  state_t           state_q;
  logic             grant_en_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic [IDX_W-1:0] ptr_q;
  logic [HC_W-1:0]  hold_cnt_q;

  logic [N_REQ-1:0] others;
  logic             winner_req;
  logic [N_REQ-1:0] pick_vec;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // Current winner's request and the remaining requesters with the winner masked off.
  assign winner_req = arb.req_i[grant_idx_q];
  assign others     = arb.req_i & ~(N_REQ'(1) << grant_idx_q);

  // One search serves both states: full vector from IDLE, competitors only while granting.
  assign pick_vec = (state_q == GRANT) ? others : arb.req_i;

  rr_priority_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req     (pick_vec),
    .start   (ptr_q),
    .found_c (pick_found),
    .idx_c   (pick_idx)
  );

  // Arbitration FSM with registered grant, search pointer and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_en_q  <= 1'b0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb.arb_en_i && pick_found) begin
            state_q     <= GRANT;
            grant_en_q  <= 1'b1;
            grant_idx_q <= pick_idx;
            ptr_q       <= pick_idx + IDX_W'(1);
            hold_cnt_q  <= '0;
          end
        end
        GRANT: begin
          if (!arb.arb_en_i) begin
            state_q    <= IDLE;
            grant_en_q <= 1'b0;
          end else if (!winner_req) begin
            if (pick_found) begin
              grant_idx_q <= pick_idx;
              ptr_q       <= pick_idx + IDX_W'(1);
              hold_cnt_q  <= '0;
            end else begin
              state_q    <= IDLE;
              grant_en_q <= 1'b0;
            end
          end else if (hold_cnt_q == HOLD_LAST) begin
            // Preempt only when someone else waits; otherwise keep the grant, counter saturated.
            if (pick_found) begin
              grant_idx_q <= pick_idx;
              ptr_q       <= pick_idx + IDX_W'(1);
              hold_cnt_q  <= '0;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          grant_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign arb.grant_en_o  = grant_en_q;
  assign arb.grant_idx_o = grant_idx_q;
  assign arb.busy_o      = grant_en_q;

endmodule

// File: doc/rr_arbiter_core.md
Name: rr_arbiter_core

Overview:
- Sequential round-robin arbiter for 8 requesters.
- Registers a 3-bit winner index plus a grant-valid flag. These feed the grant one-hot decoder directly: grant_idx_o drives its sig_i, grant_en_o drives its enable.
- Holds a grant while the winner keeps requesting. Preempts after MAX_HOLD cycles when other requesters wait.

Parameters:
- N_REQ, 8, number of requesters; power of 2, at least 2.
- IDX_W, $clog2(N_REQ) = 3, width of the grant index.
- MAX_HOLD, 16, maximum consecutive grant cycles under contention; at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arb_en_i  in  1  arbitration enable; low forces idle.
- req_i  in  N_REQ  request vector, bit k = requester k.
- grant_en_o  out  1  grant valid (registered).
- grant_idx_o  out  IDX_W  index of current winner (registered).
- busy_o  out  1  high whenever the FSM is in GRANT (equals grant_en_o).

Behaviour:
- All outputs are registered. Internal search pointer ptr_q holds the start position for the next search.
- Reset values: grant_en_o=0, grant_idx_o=0, ptr_q=0, hold_cnt=0, state=IDLE.
- pick(v, p): first set bit of v searching p, p+1, ..., wrapping modulo N_REQ. Returns "none" if v=0.
- On every new grant to index w: grant_idx_o<=w, ptr_q<=(w+1) mod N_REQ, hold_cnt<=0.
- States: IDLE, GRANT.
- IDLE, arb_en_i=0 or req_i=0:
  - Stay in IDLE, grant_en_o=0.
  - grant_idx_o keeps its last value; the decoder output is zero because enable is low.
- IDLE, arb_en_i=1 and req_i!=0:
  - Go to GRANT with w=pick(req_i, ptr_q).
  - Latency: request sampled at edge n, grant_en_o=1 after edge n.
- GRANT, priority order (first match wins):
  1. arb_en_i=0: go to IDLE, grant_en_o<=0. ptr_q is unchanged.
  2. req_i[idx]=0 (winner released), others = req_i with bit idx masked off:
     - If others!=0: stay in GRANT, new grant w=pick(others, ptr_q). No idle bubble.
     - Else: go to IDLE.
  3. hold_cnt==MAX_HOLD-1 and others!=0: preempt. New grant w=pick(others, ptr_q).
  4. hold_cnt==MAX_HOLD-1 and others=0: keep the grant; hold_cnt saturates at MAX_HOLD-1.
  5. Otherwise: hold_cnt<=hold_cnt+1.
- MAX_HOLD=1: a contended grant rotates every cycle.
- Request changes in the same cycle as a release or preempt are sampled that cycle; there are no combinational paths from req_i to outputs.
- Wrap-around: with ptr_q=N_REQ-1, the search order is 7, 0, 1, ...
- Reset asserted mid-grant: outputs clear immediately (asynchronous). After deassert, arbitration restarts from ptr_q=0.
- hold_cnt width is $clog2(MAX_HOLD)+1; it never overflows.
- Invariant: grant_en_o=1 implies the FSM is in GRANT.

Decomposition:
- Package arbiter_pkg: N_REQ, IDX_W, MAX_HOLD defaults, and enum state_t {IDLE, GRANT}.
- Sub-module rr_priority_pick: purely combinational.
  - Inputs: req vector, start pointer.
  - Outputs: found flag, IDX_W index.
  - Implementation: rotate, find first set bit, un-rotate.
- The FSM, counter and registers live in rr_arbiter_core.

Test Plan:
1. Reset, then req_i=8'h00 for 5 cycles -> grant_en_o=0, grant_idx_o=0 throughout.
2. req_i=8'h24 at cycle 0 -> cycle 1: grant_en_o=1, idx=2. Drop bit 2 -> next cycle idx=5 with grant_en_o continuous. Drop bit 5 -> grant_en_o=0 one cycle later.
3. req_i=8'hFF held constant with MAX_HOLD=4 -> idx sequence 0,0,0,0,1,1,1,1,2..., wraps 7 -> 0, each index granted exactly 4 cycles.
4. Single requester req_i=8'h80 held 40 cycles -> idx=7 continuously, no drop; hold_cnt saturates at 3.
5. Grant idx=3 active, arb_en_i driven low for 1 cycle -> grant_en_o=0 next cycle. Re-enable with req_i=8'h09 -> grant goes to idx=0 (search starts at ptr=4 and wraps), not 3.
6. Mid-grant on idx=6, assert rst_n=0 asynchronously between edges -> outputs clear immediately. After release, req_i=8'h41 -> idx=0 granted first.
